// File: rtl/axil_cmd_pkg.sv
// axil_cmd_pkg: shared types and constants for the AXI4-Lite command master
package axil_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA,
        RSP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Widest address a command can carry; narrower buses use the low bits.
    localparam int CMD_ADDR_W = 32;
    localparam int CMD_DATA_W = 32;

    typedef struct packed {
        logic                  write;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
        logic [3:0]            wstrb;
    } cmd_t;

endpackage

// File: rtl/axil_cmd_buf.sv
// axil_cmd_buf: one-entry command register used to prefetch the next command
// Ports: clk_i/rst_i (async active-high), push_i loads cmd_i, pop_i empties,
//        full_o flags occupancy, cmd_o holds the stored command.
module axil_cmd_buf
    import axil_cmd_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  logic pop_i,
    input  cmd_t cmd_i,
    output logic full_o,
    output cmd_t cmd_o
);

    logic full_q;
    cmd_t cmd_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            cmd_q  <= '0;
        end else if (push_i) begin
            full_q <= 1'b1;
            cmd_q  <= cmd_i;
        end else if (pop_i) begin
            full_q <= 1'b0;
        end
    end

    assign full_o = full_q;
    assign cmd_o  = cmd_q;

endmodule

// File: rtl/axil_cmd_master.sv
// axil_cmd_master: AXI4-Lite initiator turning single-beat commands into read/write transactions
// Ports: M_AXI_ACLK/M_AXI_ARESET (async active-high); cmd_* valid/ready command input;
//        rsp_* valid/ready response output; M_AXI_* standard AXI4-Lite master channels.
// Option: define AXIL_CMD_PREFETCH_EN to add a one-entry command buffer (axil_cmd_buf).
module axil_cmd_master
    import axil_cmd_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESET,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_wdata,
    input  logic [3:0]                    cmd_wstrb,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic                          rsp_write,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    if (C_M_AXI_DATA_WIDTH != CMD_DATA_W || C_M_AXI_ADDR_WIDTH > CMD_ADDR_W) begin : g_bad_width
        $error("axil_cmd_master: data width must be 32 and address width at most 32");
    end

    state_t state_q;
    cmd_t   cmd_c;
    cmd_t   src_c;
    logic   cmd_fire;
    logic   start;
    logic   start_valid;
    logic   launch;

    assign cmd_c = '{write: cmd_write, addr: CMD_ADDR_W'(cmd_addr), wdata: cmd_wdata, wstrb: cmd_wstrb};
    assign cmd_fire = cmd_valid && cmd_ready;
    // A new transaction may begin from IDLE or on the edge that consumes the response.
    assign start = state_q == IDLE || (state_q == RSP && rsp_ready);
    assign launch = start && start_valid;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;

`ifdef AXIL_CMD_PREFETCH_EN
    logic buf_full;
    cmd_t buf_cmd;

    // The buffered command has priority; a command arriving while the buffer is
    // empty starts directly if a start slot is open, otherwise it is parked.
    assign cmd_ready   = !buf_full && !M_AXI_ARESET;
    assign src_c       = buf_full ? buf_cmd : cmd_c;
    assign start_valid = buf_full || cmd_fire;

    axil_cmd_buf u_buf (
        .clk_i (M_AXI_ACLK),
        .rst_i (M_AXI_ARESET),
        .push_i(cmd_fire && !start),
        .pop_i (start && buf_full),
        .cmd_i (cmd_c),
        .full_o(buf_full),
        .cmd_o (buf_cmd)
    );
`else
    assign cmd_ready   = state_q == IDLE && !M_AXI_ARESET;
    assign src_c       = cmd_c;
    assign start_valid = cmd_fire;
`endif

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_q       <= IDLE;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= RESP_OKAY;
            rsp_write     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                WADDR: begin
                    if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WREADY) M_AXI_WVALID <= 1'b0;
                    // Each channel is done once its VALID has dropped or handshakes now.
                    if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
                        state_q      <= WRESP;
                        M_AXI_BREADY <= 1'b1;
                    end
                end
                WRESP: begin
                    if (M_AXI_BVALID) begin
                        state_q      <= RSP;
                        M_AXI_BREADY <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_resp     <= M_AXI_BRESP;
                        rsp_rdata    <= '0;
                    end
                end
                RADDR: begin
                    if (M_AXI_ARREADY) begin
                        state_q       <= RDATA;
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                    end
                end
                RDATA: begin
                    if (M_AXI_RVALID) begin
                        state_q      <= RSP;
                        M_AXI_RREADY <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_resp     <= M_AXI_RRESP;
                        rsp_rdata    <= M_AXI_RDATA;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        state_q   <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Launch overrides the RSP->IDLE transition above.
            if (launch) begin
                rsp_write <= src_c.write;
                if (src_c.write) begin
                    state_q       <= WADDR;
                    M_AXI_AWADDR  <= src_c.addr[C_M_AXI_ADDR_WIDTH-1:0];
                    M_AXI_WDATA   <= src_c.wdata;
                    M_AXI_WSTRB   <= src_c.wstrb;
                    M_AXI_AWVALID <= 1'b1;
                    M_AXI_WVALID  <= 1'b1;
                end else begin
                    state_q       <= RADDR;
                    M_AXI_ARADDR  <= src_c.addr[C_M_AXI_ADDR_WIDTH-1:0];
                    M_AXI_ARVALID <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axil_cmd_master.sv
// tb_axil_cmd_master: directed scoreboard bench for axil_cmd_master with a reactive AXI4-Lite slave
module tb_axil_cmd_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata_s;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp_s, rresp_s;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rsp_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axil_cmd_master dut (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESET (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_wstrb    (cmd_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_resp     (rsp_resp),
        .rsp_write    (rsp_write),
        .M_AXI_AWADDR (awaddr),
        .M_AXI_AWPROT (awprot),
        .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA  (wdata),
        .M_AXI_WSTRB  (wstrb),
        .M_AXI_WVALID (wvalid),
        .M_AXI_WREADY (wready),
        .M_AXI_BRESP  (bresp_s),
        .M_AXI_BVALID (bvalid),
        .M_AXI_BREADY (bready),
        .M_AXI_ARADDR (araddr),
        .M_AXI_ARPROT (arprot),
        .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA  (rdata_s),
        .M_AXI_RRESP  (rresp_s),
        .M_AXI_RVALID (rvalid),
        .M_AXI_RREADY (rready)
    );

    // Slave model: READY after a programmable number of VALID cycles,
    // B/R response registered on the cycle after the address/data handshakes.
    int          aw_dly = 0, w_dly = 0, ar_dly = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = 32'h0;
    logic        r_off = 1'b0;
    int          aw_cnt, w_cnt, ar_cnt, aw_hs_cyc, w_hs_cyc;
    logic        aw_got, w_got;
    logic [31:0] slv_awaddr, slv_wdata;
    logic [3:0]  slv_wstrb;
    logic        aw_hs, w_hs;

    assign awready = awvalid && aw_cnt >= aw_dly;
    assign wready  = wvalid && w_cnt >= w_dly;
    assign arready = arvalid && ar_cnt >= ar_dly;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0;
            bvalid <= 1'b0; rvalid <= 1'b0;
            bresp_s <= 2'b00; rresp_s <= 2'b00; rdata_s <= 32'h0;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
            ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
            if (aw_hs) begin
                slv_awaddr <= awaddr;
                aw_hs_cyc  <= cyc;
            end
            if (w_hs) begin
                slv_wdata <= wdata;
                slv_wstrb <= wstrb;
                w_hs_cyc  <= cyc;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                bvalid  <= 1'b1;
                bresp_s <= cfg_bresp;
                aw_got  <= 1'b0;
                w_got   <= 1'b0;
            end else begin
                aw_got <= aw_got || aw_hs;
                w_got  <= w_got || w_hs;
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready && !r_off) begin
                rvalid  <= 1'b1;
                rdata_s <= cfg_rdata;
                rresp_s <= cfg_rresp;
            end
        end
    end

    typedef struct {
        logic        w;
        logic [31:0] d;
        logic [1:0]  r;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Response monitor: every consumed response is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            rsp_cnt++;
            chk("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
            if (sbq.size() != 0) begin
                mon_e = sbq.pop_front();
                chk("rsp_write", 64'(rsp_write), 64'(mon_e.w));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.d));
                chk("rsp_resp", 64'(rsp_resp), 64'(mon_e.r));
            end
        end
    end

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] rd, input logic [1:0] rr);
        int k = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        sbq.push_back('{w, w ? 32'h0 : rd, rr});
        while (!cmd_ready && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("cmd_ready_at_accept", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 1;
        while (!rsp_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic drain();
        int k = 0;
        while (sbq.size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("drain", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, bad, rc0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        cmd_wstrb = 4'h0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_axi_handshake", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
        chk("rst_rsp", 64'({rsp_valid, rsp_write, rsp_resp, rsp_rdata}), 64'd0);
        chk("rst_addr", {awaddr, araddr}, 64'd0);
        chk("rst_wdata", 64'({wdata, wstrb}), 64'd0);
        chk("rst_prot", 64'({awprot, arprot}), 64'd0);
        rst = 1'b0;
        #1;
        chk("cmd_ready_after_release", 64'(cmd_ready), 64'd1);

        // Write to an always-ready slave.
        send(1'b1, 32'h78E0_0000, 32'h0000_F800, 4'hF, 32'h0, 2'b00);
        wait_rsp(n);
        chk("write_latency", 64'(n), 64'd3);
        drain();
        chk("aw_w_same_cycle", 64'(aw_hs_cyc), 64'(w_hs_cyc));
        chk("slv_awaddr", 64'(slv_awaddr), 64'h78E0_0000);
        chk("slv_wdata", 64'(slv_wdata), 64'h0000_F800);
        chk("slv_wstrb", 64'(slv_wstrb), 64'hF);

        // Read with ARREADY delayed 4 cycles.
        ar_dly = 4;
        cfg_rdata = 32'h1234_5678;
        send(1'b0, 32'h78E0_0004, 32'h0, 4'h0, 32'h1234_5678, 2'b00);
        n = 0;
        bad = 0;
        while (arvalid && n < 50) begin
            n++;
            if (araddr !== 32'h78E0_0004) bad = 1;
            @(posedge clk);
            #1;
        end
        chk("arvalid_hold_cycles", 64'(n), 64'd5);
        chk("araddr_stable", 64'(bad), 64'd0);
        drain();
        ar_dly = 0;

        // W completes 3 cycles before AW.
        aw_dly = 3;
        rc0 = rsp_cnt;
        send(1'b1, 32'h78E0_0008, 32'hDEAD_BEEF, 4'h5, 32'h0, 2'b00);
        @(posedge clk);
        #1;
        chk("w_drops_aw_held", 64'({wvalid, awvalid}), 64'b01);
        drain();
        chk("aw_minus_w_cycles", 64'(aw_hs_cyc - w_hs_cyc), 64'd3);
        repeat (4) @(posedge clk);
        #1;
        chk("single_response", 64'(rsp_cnt - rc0), 64'd1);
        aw_dly = 0;

        // SLVERR passthrough with rsp_ready held low.
        cfg_bresp = 2'b10;
        rsp_ready = 1'b0;
        send(1'b1, 32'h78E0_000C, 32'h0000_A5A5, 4'h3, 32'h0, 2'b10);
        wait_rsp(n);
        for (int i = 0; i < 5; i++) begin
            chk("rsp_stable", 64'({rsp_valid, rsp_write, rsp_resp, rsp_rdata}), 64'({1'b1, 1'b1, 2'b10, 32'h0}));
`ifndef AXIL_CMD_PREFETCH_EN
            chk("no_accept_in_rsp", 64'(cmd_ready), 64'd0);
`endif
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("consumed_ready", 64'({rsp_valid, cmd_ready}), 64'b01);
        drain();
        cfg_bresp = 2'b00;

`ifdef AXIL_CMD_PREFETCH_EN
        // Second write accepted during WRESP, launched on the response handshake.
        send(1'b1, 32'h78E0_0010, 32'h1111_1111, 4'hF, 32'h0, 2'b00);
        @(posedge clk);
        #1;
        chk("pf_in_wresp", 64'(bready), 64'd1);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h78E0_0014;
        cmd_wdata = 32'h2222_2222;
        cmd_wstrb = 4'hF;
        sbq.push_back('{1'b1, 32'h0, 2'b00});
        chk("pf_ready_busy", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("pf_rsp_first", 64'({rsp_valid, awvalid}), 64'b10);
        @(posedge clk);
        #1;
        chk("pf_aw_after_rsp", 64'({rsp_valid, awvalid}), 64'b01);
        drain();
        chk("pf_second_addr", 64'(slv_awaddr), 64'h78E0_0014);
`endif

        // Reset asserted while waiting in RDATA.
        r_off = 1'b1;
        send(1'b0, 32'h78E0_0018, 32'h0, 4'h0, 32'h0, 2'b00);
        @(posedge clk);
        #1;
        chk("in_rdata", 64'({arvalid, rready}), 64'b01);
        rst = 1'b1;
        #1;
        chk("mid_rst_handshake", 64'({rready, arvalid, rsp_valid, cmd_ready}), 64'd0);
        chk("mid_rst_araddr", 64'(araddr), 64'd0);
        sbq.delete();
        r_off = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("ready_after_mid_rst", 64'(cmd_ready), 64'd1);

        // Recovery read returning DECERR.
        cfg_rdata = 32'hCAFE_F00D;
        cfg_rresp = 2'b11;
        send(1'b0, 32'h78E0_001C, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b11);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
